// File: rtl/stack_monitor_if.sv
// Register bus between an initiator and the stack monitor: strobe/ack handshake with one wait state.
interface stack_monitor_if;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, we, addr, data_in, input data_out, ack);
  modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/stack_monitor.sv
// Stack pointer watchdog: tracks the lowest SP seen and raises sticky overflow/warning flags
// when the registered SP drops strictly below programmable LIMIT/WARN thresholds.
module stack_monitor #(
  parameter logic [31:0] LIMIT_INIT = 32'h0000_0000,
  parameter logic [31:0] WARN_INIT  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  stack_monitor_if.slave bus,
  input  logic [31:0] spx,
  output logic        trap,
  output logic        warn
);

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_LIMIT = 2'd1;
  localparam logic [1:0] A_HWM   = 2'd2;
  localparam logic [1:0] A_WARN  = 2'd3;

  logic        stb_seen_q;
  logic        ack_q, ack_d;
  logic [31:0] dout_q, dout_d;
  logic        enable_q, enable_d;
  logic        trap_en_q, trap_en_d;
  logic        ovf_q, ovf_d;
  logic        wrn_q, wrn_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] warn_q, warn_d;
  logic [31:0] hwm_q, hwm_d;
  logic [31:0] spx_q;
  logic        take, wr;
  logic [31:0] rdata;

  always_comb begin
    // One transfer per strobe assertion: only a rising stb is accepted.
    take      = bus.stb & ~stb_seen_q;
    wr        = take & bus.we;
    rdata     = 32'h0;
    enable_d  = enable_q;
    trap_en_d = trap_en_q;
    limit_d   = limit_q;
    warn_d    = warn_q;
    hwm_d     = hwm_q;
    ovf_d     = ovf_q;
    wrn_d     = wrn_q;

    case (bus.addr)
      A_CTRL:  rdata = {28'h0, wrn_q, ovf_q, trap_en_q, enable_q};
      A_LIMIT: rdata = limit_q;
      A_HWM:   rdata = hwm_q;
      default: rdata = warn_q;
    endcase

    if (wr) begin
      case (bus.addr)
        A_CTRL: begin
          enable_d  = bus.data_in[0];
          trap_en_d = bus.data_in[1];
          if (bus.data_in[2]) ovf_d = 1'b0;
          if (bus.data_in[3]) wrn_d = 1'b0;
        end
        A_LIMIT: limit_d = bus.data_in;
        A_WARN:  warn_d  = bus.data_in;
        default: ;
      endcase
    end

    // Set after clear so a coincident set condition wins over write-1-to-clear.
    if (enable_q && (spx_q < limit_q)) ovf_d = 1'b1;
    if (enable_q && (spx_q < warn_q))  wrn_d = 1'b1;

    if (wr && (bus.addr == A_HWM))          hwm_d = 32'hFFFF_FFFF;
    else if (enable_q && (spx_q < hwm_q))   hwm_d = spx_q;

    ack_d  = take;
    dout_d = take ? rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= 32'h0;
      enable_q   <= 1'b0;
      trap_en_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wrn_q      <= 1'b0;
      limit_q    <= LIMIT_INIT;
      warn_q     <= WARN_INIT;
      hwm_q      <= 32'hFFFF_FFFF;
      spx_q      <= 32'hFFFF_FFFF;
    end else begin
      stb_seen_q <= bus.stb;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      enable_q   <= enable_d;
      trap_en_q  <= trap_en_d;
      ovf_q      <= ovf_d;
      wrn_q      <= wrn_d;
      limit_q    <= limit_d;
      warn_q     <= warn_d;
      hwm_q      <= hwm_d;
      spx_q      <= spx;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.data_out = dout_q;
  assign trap         = ovf_q & trap_en_q;
  assign warn         = wrn_q;

endmodule

// File: tb/tb_stack_monitor.sv
// Bench for stack_monitor: directed scenarios against fixed expectations, then random
// bus/SP traffic compared cycle by cycle with a behavioural reference model.
module tb_stack_monitor;

  logic        clk;
  logic        rst;
  logic [31:0] spx;
  logic        trap, warn;
  int          tests, fails;

  stack_monitor_if bif ();

  stack_monitor dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bif),
    .spx  (spx),
    .trap (trap),
    .warn (warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Registers are held as a plain map; the SP seen by the comparators is the previous cycle's input.
  logic        m_prev_stb, m_ack;
  logic [31:0] m_dout;
  logic        m_en, m_ten, m_ovf, m_wrn;
  logic [31:0] m_lim, m_wlim, m_low, m_sp;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_wrn, m_ovf, m_ten, m_en};
      2'd1:    return m_lim;
      2'd2:    return m_low;
      default: return m_wlim;
    endcase
  endfunction

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prev_stb <= 1'b0; m_ack <= 1'b0; m_dout <= 32'h0;
      m_en <= 1'b0; m_ten <= 1'b0; m_ovf <= 1'b0; m_wrn <= 1'b0;
      m_lim <= 32'h0; m_wlim <= 32'h0; m_low <= 32'hFFFF_FFFF; m_sp <= 32'hFFFF_FFFF;
    end else begin
      m_prev_stb <= bif.stb;
      m_ack      <= bif.stb && !m_prev_stb;
      m_dout     <= (bif.stb && !m_prev_stb) ? m_read(bif.addr) : 32'h0;
      m_sp       <= spx;
      if (bif.stb && !m_prev_stb && bif.we && bif.addr == 2'd0) begin
        m_en  <= bif.data_in[0];
        m_ten <= bif.data_in[1];
      end
      if (bif.stb && !m_prev_stb && bif.we && bif.addr == 2'd1) m_lim  <= bif.data_in;
      if (bif.stb && !m_prev_stb && bif.we && bif.addr == 2'd3) m_wlim <= bif.data_in;
      m_ovf <= (m_en && m_sp < m_lim) ||
               (m_ovf && !(bif.stb && !m_prev_stb && bif.we && bif.addr == 2'd0 && bif.data_in[2]));
      m_wrn <= (m_en && m_sp < m_wlim) ||
               (m_wrn && !(bif.stb && !m_prev_stb && bif.we && bif.addr == 2'd0 && bif.data_in[3]));
      if (bif.stb && !m_prev_stb && bif.we && bif.addr == 2'd2) m_low <= 32'hFFFF_FFFF;
      else if (m_en)                                          m_low <= min32(m_low, m_sp);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = 32'h0;
    @(negedge clk);
    bif.stb = 1'b1; bif.we = w; bif.addr = a; bif.data_in = d;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (bif.ack === 1'b1) begin
        got = 1;
        rd  = bif.data_out;
      end
    end
    bif.stb = 1'b0; bif.we = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL bus_ack addr=%0d: ack=0 after 6 cycles, required ack=1", a);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, dummy);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0;
    wait_cyc(2);
    tests++;
    if ({bif.ack, trap, warn} !== 3'b000 || bif.data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b trap=%b warn=%b dout=%h, required all 0",
               bif.ack, trap, warn, bif.data_out);
    end
    rst = 1'b1;
    wait_cyc(1);
    bus_xfer(1'b0, 2'd0, 32'h0, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h, required %h", rd, 32'h0); end
    bus_xfer(1'b0, 2'd1, 32'h0, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_limit: got %h, required %h", rd, 32'h0); end
    bus_xfer(1'b0, 2'd2, 32'h0, rd);
    tests++; if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_hwm: got %h, required %h", rd, 32'hFFFF_FFFF); end
    bus_xfer(1'b0, 2'd3, 32'h0, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_warn: got %h, required %h", rd, 32'h0); end
    wr_reg(2'd0, 32'hFFFF_FFF0);
    bus_xfer(1'b0, 2'd0, 32'h0, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ctrl_upper_ignored: got %h, required %h", rd, 32'h0); end
  endtask

  task automatic test_trap();
    logic [31:0] rd;
    wr_reg(2'd1, 32'h0000_8000);
    wr_reg(2'd0, 32'h3);
    spx = 32'h0000_8000;
    wait_cyc(4);
    tests++; if (trap !== 1'b0) begin fails++; $display("FAIL trap_equal_limit: got %b, required 0", trap); end
    spx = 32'h0000_7FFC;
    @(negedge clk);
    tests++; if (trap !== 1'b0) begin fails++; $display("FAIL trap_latency_1: got %b, required 0", trap); end
    @(negedge clk);
    tests++; if (trap !== 1'b1) begin fails++; $display("FAIL trap_latency_2: got %b, required 1", trap); end
    bus_xfer(1'b0, 2'd0, 32'h0, rd);
    tests++; if (rd !== 32'h7) begin fails++; $display("FAIL trap_ctrl: got %h, required %h", rd, 32'h7); end
  endtask

  task automatic test_hwm();
    logic [31:0] rd;
    spx = 32'h0000_9000; wait_cyc(3);
    wr_reg(2'd2, 32'h0);
    wait_cyc(1);
    spx = 32'h0000_8800; wait_cyc(3);
    spx = 32'h0000_9400; wait_cyc(3);
    bus_xfer(1'b0, 2'd2, 32'h0, rd);
    tests++; if (rd !== 32'h0000_8800) begin fails++; $display("FAIL hwm_min: got %h, required %h", rd, 32'h0000_8800); end
    spx = 32'hFFFF_FFFF; wait_cyc(3);
    wr_reg(2'd2, 32'h0000_1234);
    bus_xfer(1'b0, 2'd2, 32'h0, rd);
    tests++; if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL hwm_reload: got %h, required %h", rd, 32'hFFFF_FFFF); end
    spx = 32'h0000_9100; wait_cyc(3);
    bus_xfer(1'b0, 2'd2, 32'h0, rd);
    tests++; if (rd !== 32'h0000_9100) begin fails++; $display("FAIL hwm_track: got %h, required %h", rd, 32'h0000_9100); end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    spx = 32'h0000_7000; wait_cyc(3);
    wr_reg(2'd0, 32'h7);
    bus_xfer(1'b0, 2'd0, 32'h0, rd);
    tests++; if (rd !== 32'h7) begin fails++; $display("FAIL set_wins_ctrl: got %h, required %h", rd, 32'h7); end
    tests++; if (trap !== 1'b1) begin fails++; $display("FAIL set_wins_trap: got %b, required 1", trap); end
    spx = 32'h0000_9000; wait_cyc(3);
    wr_reg(2'd0, 32'h7);
    bus_xfer(1'b0, 2'd0, 32'h0, rd);
    tests++; if (rd !== 32'h3) begin fails++; $display("FAIL w1c_ctrl: got %h, required %h", rd, 32'h3); end
    tests++; if (trap !== 1'b0) begin fails++; $display("FAIL w1c_trap: got %b, required 0", trap); end
  endtask

  task automatic test_hold_stb();
    int acks;
    acks = 0;
    @(negedge clk);
    bif.stb = 1'b1; bif.we = 1'b0; bif.addr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bif.ack === 1'b1) acks++;
      tests++;
      if (bif.data_out !== ((i == 0) ? 32'h0000_8000 : 32'h0)) begin
        fails++;
        $display("FAIL hold_dout cyc=%0d: got %h, required %h", i, bif.data_out,
                 (i == 0) ? 32'h0000_8000 : 32'h0);
      end
    end
    bif.stb = 1'b0;
    tests++; if (acks != 1) begin fails++; $display("FAIL hold_ack_count: got %0d, required 1", acks); end
  endtask

  task automatic test_warn();
    logic [31:0] rd;
    wr_reg(2'd3, 32'h0000_A000);
    wr_reg(2'd0, 32'h1);
    spx = 32'h0000_9FFC; wait_cyc(3);
    tests++; if ({warn, trap} !== 2'b10) begin fails++; $display("FAIL warn_only: warn=%b trap=%b, required warn=1 trap=0", warn, trap); end
    spx = 32'h0000_7000; wait_cyc(3);
    tests++; if ({warn, trap} !== 2'b10) begin fails++; $display("FAIL warn_ovf_no_trap: warn=%b trap=%b, required warn=1 trap=0", warn, trap); end
    bus_xfer(1'b0, 2'd0, 32'h0, rd);
    tests++; if (rd !== 32'hD) begin fails++; $display("FAIL warn_ctrl: got %h, required %h", rd, 32'hD); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit got;
    @(negedge clk);
    bif.stb = 1'b1; bif.we = 1'b1; bif.addr = 2'd1; bif.data_in = 32'h0000_1234;
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({bif.ack, trap, warn} !== 3'b000 || bif.data_out !== 32'h0) begin
      fails++;
      $display("FAIL midreset_outputs: ack=%b trap=%b warn=%b dout=%h, required all 0",
               bif.ack, trap, warn, bif.data_out);
    end
    wait_cyc(2);
    tests++; if (bif.ack !== 1'b0) begin fails++; $display("FAIL midreset_no_ack: got %b, required 0", bif.ack); end
    bif.stb = 1'b0; bif.we = 1'b0;
    rst = 1'b1;
    bus_xfer(1'b0, 2'd1, 32'h0, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL midreset_limit: got %h, required %h", rd, 32'h0); end
    // Strobe held through reset release is a fresh transfer.
    @(negedge clk);
    bif.stb = 1'b1; bif.we = 1'b0; bif.addr = 2'd2;
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bif.ack === 1'b1) begin got = 1; rd = bif.data_out; end
    end
    bif.stb = 1'b0;
    tests++; if (!got) begin fails++; $display("FAIL postreset_ack: ack=0 after 4 cycles, required ack=1"); end
    tests++; if (got && rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL postreset_hwm: got %h, required %h", rd, 32'hFFFF_FFFF); end
  endtask

  task automatic test_random();
    int wait_n, hold_n, printed;
    bit acked;
    wait_n = 0; hold_n = 0; acked = 0; printed = 0;
    wr_reg(2'd1, 32'h0000_0180);
    wr_reg(2'd3, 32'h0000_0200);
    wr_reg(2'd0, 32'h3);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      tests++;
      if (bif.ack !== m_ack || bif.data_out !== m_dout || trap !== (m_ovf & m_ten) || warn !== m_wrn) begin
        fails++;
        if (printed < 20) begin
          printed++;
          $display("FAIL random cyc=%0d: ack=%b dout=%h trap=%b warn=%b, required ack=%b dout=%h trap=%b warn=%b",
                   c, bif.ack, bif.data_out, trap, warn, m_ack, m_dout, m_ovf & m_ten, m_wrn);
        end
      end
      spx = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(32'h100, 32'h2C0));
      if (!bif.stb) begin
        if ($urandom_range(0, 2) == 0) begin
          bif.stb = 1'b1;
          bif.we  = 1'($urandom_range(0, 1));
          bif.addr = 2'($urandom_range(0, 3));
          case (bif.addr)
            2'd0:    bif.data_in = 32'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 0) ? 32'h0 : 32'h1);
            2'd2:    bif.data_in = $urandom;
            default: bif.data_in = 32'($urandom_range(32'h100, 32'h2C0));
          endcase
          wait_n = 0; acked = 0; hold_n = $urandom_range(0, 3);
        end
      end else begin
        wait_n++;
        if (bif.ack === 1'b1) acked = 1;
        if (acked) begin
          if (hold_n == 0) begin bif.stb = 1'b0; bif.we = 1'b0; end
          else hold_n--;
        end else if (wait_n > 6) begin
          tests++; fails++;
          $display("FAIL random_ack_timeout cyc=%0d: ack=0 after 6 cycles, required ack=1", c);
          bif.stb = 1'b0; bif.we = 1'b0;
        end
      end
    end
    @(negedge clk);
    bif.stb = 1'b0; bif.we = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0;
    spx = 32'hFFFF_FFFF;
    bif.stb = 1'b0; bif.we = 1'b0; bif.addr = 2'd0; bif.data_in = 32'h0;
    test_reset();
    test_trap();
    test_hwm();
    test_set_wins();
    test_hold_stb();
    test_warn();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_monitor.md
STACK_MONITOR -- requirements
Module: stack_monitor

Interface
REQ-001 Parameter LIMIT_INIT, default 32'h00000000, reset value of the LIMIT register.
REQ-002 Parameter WARN_INIT, default 32'h00000000, reset value of the WARN register.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port stb  input  1  bus strobe from the initiator; held high until ack is seen.
REQ-006 Port we  input  1  bus write enable, qualified by stb.
REQ-007 Port addr  input  2  register select (word address bits 3:2).
REQ-008 Port data_in  input  32  write data from the initiator.
REQ-009 Port data_out  output  32  read data to the initiator.
REQ-010 Port ack  output  1  bus acknowledge, one-cycle pulse.
REQ-011 Port spx  input  32  CPU stack pointer value, sampled every cycle.
REQ-012 Port trap  output  1  stack overflow trap request, level.
REQ-013 Port warn  output  1  stack warning, level.

Function
REQ-014 Register map SHALL be: 0 CTRL/STATUS, 1 LIMIT, 2 HWM (minimum spx seen), 3 WARN.
REQ-015 CTRL bit0 = enable, bit1 = trap_en (R/W); bit2 = ovf (sticky, write-1-to-clear); bit3 = wrn (sticky, write-1-to-clear); bits 31:4 read 0, writes ignored.
REQ-016 Bus handshake: ack SHALL assert on the edge after stb is first sampled high with ack low, for exactly one cycle; stb high with ack high SHALL NOT produce a second ack (one transfer per stb assertion, one wait state).
REQ-017 Write side effects SHALL occur at the same edge that raises ack; a read with no ack SHALL have no side effects.
REQ-018 data_out SHALL be registered, carry the addressed register during the ack cycle, and be 32'h0 in all other cycles.
REQ-019 spx SHALL be registered into spx_q each cycle; all comparisons use spx_q.
REQ-020 HWM SHALL update to spx_q when enable=1 and spx_q < HWM (unsigned); any write to HWM SHALL reload 32'hFFFFFFFF regardless of data_in.
REQ-021 ovf SHALL set when enable=1 and spx_q < LIMIT (unsigned); wrn SHALL set when enable=1 and spx_q < WARN (unsigned).
REQ-022 Latency: spx presented before edge k -> spx_q at k -> ovf/wrn/HWM update at k+1.
REQ-023 trap SHALL equal ovf AND trap_en (combinational from registers); warn SHALL equal wrn.
REQ-024 Simultaneous set condition and write-1-to-clear on the same edge: set SHALL win.
REQ-025 Simultaneous HWM write and HWM update condition: the write (reload to all-ones) SHALL win.
REQ-026 enable=0 SHALL freeze HWM and block setting of ovf/wrn; existing flags SHALL remain until cleared.
REQ-027 spx_q equal to LIMIT or WARN SHALL NOT set a flag (strict less-than).

Reset
REQ-028 On rst low, asynchronously: ack=0, data_out=0, CTRL=0, ovf=0, wrn=0, LIMIT=LIMIT_INIT, WARN=WARN_INIT, HWM=32'hFFFFFFFF, spx_q=32'hFFFFFFFF; trap=0, warn=0.
REQ-029 Reset asserted mid-transfer SHALL abort it with no ack and no register write; after release, a still-high stb SHALL be acknowledged as a new transfer.

Verification
REQ-030 Write LIMIT=32'h0000_8000, CTRL=32'h3, drive spx=32'h0000_8000 then 32'h0000_7FFC -> no trap at 8000; trap=1 two edges after 7FFC; CTRL reads 32'h7.
REQ-031 Drive spx 32'h0000_9000, 32'h0000_8800, 32'h0000_9400 with enable=1 -> HWM reads 32'h0000_8800; write HWM any value -> reads 32'hFFFF_FFFF then tracks the next spx.
REQ-032 ovf set, spx still below LIMIT, write CTRL=32'h7 -> ovf stays 1 (set wins); raise spx above LIMIT, write CTRL=32'h7 -> ovf=0, trap=0.
REQ-033 Hold stb high for 4 cycles on a read of addr 1 -> exactly one ack pulse, data_out = LIMIT only in that cycle, 0 otherwise.
REQ-034 WARN=32'h0000_A000, trap_en=0, spx=32'h0000_9FFC -> warn=1, trap=0 even when ovf also set.
REQ-035 Pulse rst low during an un-acked write of LIMIT=32'h1234 -> LIMIT reads LIMIT_INIT, all outputs 0 during reset, next stb acked normally.
